// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared definitions for the load/store unit: access size
//               encodings, FSM state type and the default data-space size.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  // Default addressable data space in bytes (word index = addr[9:2]).
  localparam int unsigned MEM_BYTES = 1024;

  // req_size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational lane handling for the load/store unit.
//               Extracts and extends load data from a memory word, and merges
//               right-aligned store data into the addressed lanes of a word.
// Ports       : size_i       access size (SZ_*)
//               unsigned_i   1 = zero-extend loads, 0 = sign-extend
//               addr_lo_i    byte offset within the word (little-endian)
//               rd_word_i    word currently held in memory
//               wdata_i      right-aligned store data
//               load_data_o  extended load result
//               store_word_o full word to write back
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    load_data_o = '0;
    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'b0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = unsigned_i ? {16'b0, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: load_data_o = rd_word_i;
      default: load_data_o = '0;
    endcase
  end

  // Sub-word stores keep every byte of the old word except the addressed lanes.
  always_comb begin
    store_word_o = rd_word_i;
    case (size_i)
      SZ_BYTE: store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (addr_lo_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else              store_word_o[15:0]  = wdata_i[15:0];
      end
      SZ_WORD: store_word_o = wdata_i;
      default: store_word_o = rd_word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit in front of a word-wide
//               data memory. IDLE accepts a request, ACCESS drives memory for
//               one cycle (read-modify-write for sub-word stores), RESP holds
//               the response until it is accepted.
// Ports       : clk/rst_n         clock, async active-low reset
//               req_*             request handshake and fields
//               resp_*            response handshake, data and error flag
//               dm_*              word-memory interface (combinational read)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = load_store_unit_pkg::MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        access_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_lane_align u_lane_align (
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .addr_lo_i    (addr_q[1:0]),
    .rd_word_i    (dm_read_data),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_comb begin
    access_err = (size_q == SZ_ILL)
               | ((size_q == SZ_HALF) & addr_q[0])
               | ((size_q == SZ_WORD) & (addr_q[1:0] != 2'b00))
               | (addr_q >= MEM_BYTES);
  end

  // Memory strobes derive only from the registered state, so an async reset
  // during ACCESS drops dm_mem_write before the write edge arrives.
  always_comb begin
    dm_mem_read   = 1'b0;
    dm_mem_write  = 1'b0;
    dm_addr       = '0;
    dm_write_data = '0;
    if (state_q == ACCESS && !access_err) begin
      dm_addr = {addr_q[31:2], 2'b00};
      if (!write_q) begin
        dm_mem_read = 1'b1;
      end else begin
        dm_mem_write  = 1'b1;
        dm_write_data = store_word;
        dm_mem_read   = (size_q != SZ_WORD);  // sub-word store needs the old word
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        err_d   = access_err;
        rdata_d = (access_err || write_q) ? 32'h0 : load_data;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               behavioural word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          wr_cnt = 0;
  int          rmw_cnt = 0;

  logic        acc_rd, acc_wr;
  logic [31:0] acc_addr, acc_wdata;
  int          wr_before;
  int          rmw_before;
  logic [31:0] held_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .dm_mem_read   (dm_mem_read),
    .dm_mem_write  (dm_mem_write),
    .dm_addr       (dm_addr),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data)
  );

  assign dm_read_data = mem[dm_addr[9:2]];

  always @(posedge clk) begin
    if (dm_mem_write) begin
      mem[dm_addr[9:2]] <= dm_write_data;
      wr_cnt <= wr_cnt + 1;
      if (dm_mem_read) rmw_cnt <= rmw_cnt + 1;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Present one request, capture the ACCESS-cycle memory strobes, and stop
  // at the first cycle the response should be visible.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    acc_rd = dm_mem_read; acc_wr = dm_mem_write;
    acc_addr = dm_addr; acc_wdata = dm_write_data;
    check("req_ready_access", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("resp_valid_latency", {31'b0, resp_valid}, 32'd1);
  endtask

  task automatic take();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after_resp", {31'b0, req_ready}, 32'd1);
    check("resp_valid_after_resp", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    // Memory image loaded while the unit is held in reset.
    preload(8'h04, 32'h8877_6655);   // 0x10
    preload(8'h08, 32'hAABB_CCDD);   // 0x20
    preload(8'h0C, 32'h1111_2222);   // 0x30
    preload(8'h10, 32'h0102_0304);   // 0x40
    preload(8'h11, 32'h0000_0000);   // 0x44
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready",  {31'b0, req_ready},    32'd1);
    check("rst_resp_valid", {31'b0, resp_valid},   32'd0);
    check("rst_resp_err",   {31'b0, resp_err},     32'd0);
    check("rst_resp_rdata", resp_rdata,            32'h0);
    check("rst_dm_read",    {31'b0, dm_mem_read},  32'd0);
    check("rst_dm_write",   {31'b0, dm_mem_write}, 32'd0);
    check("rst_dm_addr",    dm_addr,               32'h0);

    // Signed byte load from the top lane.
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_dm_read", {31'b0, acc_rd}, 32'd1);
    check("lb_dm_write", {31'b0, acc_wr}, 32'd0);
    check("lb_dm_addr", acc_addr, 32'h10);
    check("lb_rdata", resp_rdata, 32'hFFFF_FF88);
    check("lb_err", {31'b0, resp_err}, 32'd0);
    take();

    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lbu_rdata", resp_rdata, 32'h0000_0088);
    take();

    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lh_rdata", resp_rdata, 32'hFFFF_8877);
    take();

    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check("lhu_rdata", resp_rdata, 32'h0000_6655);
    take();

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rdata", resp_rdata, 32'h8877_6655);
    take();

    // Half store into the upper lanes: read-modify-write in one cycle.
    wr_before = wr_cnt; rmw_before = rmw_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hDEAD_1234);
    check("sh_dm_read", {31'b0, acc_rd}, 32'd1);
    check("sh_dm_write", {31'b0, acc_wr}, 32'd1);
    check("sh_dm_addr", acc_addr, 32'h20);
    check("sh_dm_wdata", acc_wdata, 32'h1234_CCDD);
    check("sh_rdata", resp_rdata, 32'h0);
    check("sh_err", {31'b0, resp_err}, 32'd0);
    check("sh_write_cycles", wr_cnt - wr_before, 32'd1);
    check("sh_rmw_cycles", rmw_cnt - rmw_before, 32'd1);
    take();
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("sh_readback", resp_rdata, 32'h1234_CCDD);
    take();

    // Byte store into lane 1 preserves the other three bytes.
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF5A);
    check("sb_dm_wdata", acc_wdata, 32'h1234_5ADD);
    take();
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("sb_readback", resp_rdata, 32'h1234_5ADD);
    take();

    // Aligned word store: write only, no read.
    issue(1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFE_BABE);
    check("sw_dm_read", {31'b0, acc_rd}, 32'd0);
    check("sw_dm_write", {31'b0, acc_wr}, 32'd1);
    check("sw_dm_wdata", acc_wdata, 32'hCAFE_BABE);
    take();
    issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    check("sw_readback", resp_rdata, 32'hCAFE_BABE);
    take();

    // Misaligned word store: error, no write, memory unchanged.
    wr_before = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h41, 32'hFFFF_FFFF);
    check("sw_mis_dm_write", {31'b0, acc_wr}, 32'd0);
    check("sw_mis_err", {31'b0, resp_err}, 32'd1);
    check("sw_mis_rdata", resp_rdata, 32'h0);
    check("sw_mis_no_write", wr_cnt - wr_before, 32'd0);
    take();
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    check("sw_mis_word_kept", resp_rdata, 32'h0102_0304);
    take();

    // Out-of-range load at exactly MEM_BYTES.
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    check("oor_dm_read", {31'b0, acc_rd}, 32'd0);
    check("oor_err", {31'b0, resp_err}, 32'd1);
    check("oor_rdata", resp_rdata, 32'h0);
    take();

    // Last in-range word is legal.
    issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    check("edge_err", {31'b0, resp_err}, 32'd0);
    take();

    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    check("lh_mis_err", {31'b0, resp_err}, 32'd1);
    check("lh_mis_dm_read", {31'b0, acc_rd}, 32'd0);
    take();

    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check("ill_size_err", {31'b0, resp_err}, 32'd1);
    check("ill_size_rdata", resp_rdata, 32'h0);
    take();

    // Backpressure: response held for five cycles, accepted on the sixth.
    issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    held_rdata = resp_rdata;
    check("bp_rdata", held_rdata, 32'h0000_0055);
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata_stable", resp_rdata, 32'h0000_0055);
      check("bp_err_stable", {31'b0, resp_err}, 32'd0);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    check("bp_resp_valid_6", {31'b0, resp_valid}, 32'd1);
    take();

    // Reset dropped during the ACCESS cycle of a word store.
    wr_before = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_acc_dm_write", {31'b0, dm_mem_write}, 32'd0);
    check("rst_acc_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_acc_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_acc_resp_valid_after", {31'b0, resp_valid}, 32'd0);
    check("rst_acc_no_write", wr_cnt - wr_before, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("rst_acc_word_kept", resp_rdata, 32'h1111_2222);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
